// File: rtl/sys_cfg_pkg.sv
// Shared system-configuration constants: exported entry indices, UART config
// field layout and the reset defaults of the configuration registers.
package sys_cfg_pkg;

  localparam int REG_ALU_A     = 0;
  localparam int REG_ALU_B     = 1;
  localparam int REG_UART_CFG  = 2;
  localparam int REG_DIV_RATIO = 3;

  localparam int PAR_EN_BIT    = 0;
  localparam int PAR_TYP_BIT   = 1;
  localparam int PRESCALE_LSB  = 2;
  localparam int PRESCALE_MSB  = 7;

  typedef struct packed {
    logic [PRESCALE_MSB-PRESCALE_LSB:0] prescale;
    logic                               parTyp;
    logic                               parEn;
  } uart_cfg_t;

  // Parity enabled, even parity, prescale of 32.
  localparam uart_cfg_t  UART_CFG_RST  = '{prescale: 6'd32, parTyp: 1'b0, parEn: 1'b1};
  localparam logic [7:0] DIV_RATIO_RST = 8'd32;

endpackage

// File: rtl/reg_file_cfg_if.sv
// Controller-side bus of the configuration register file. Par_Err exists only
// when REG_FILE_PARITY_EN is defined.
interface reg_file_cfg_if #(
  parameter int WIDTH = 8,
  parameter int ADDR  = 4
);
  logic             WrEn;
  logic             RdEn;
  logic [ADDR-1:0]  Address;
  logic [WIDTH-1:0] WrData;
  logic [WIDTH-1:0] RdData;
  logic             RdData_Valid;
  logic             Addr_Err;
`ifdef REG_FILE_PARITY_EN
  logic             Par_Err;

  modport master (output WrEn, RdEn, Address, WrData,
                  input  RdData, RdData_Valid, Addr_Err, Par_Err);
  modport slave  (input  WrEn, RdEn, Address, WrData,
                  output RdData, RdData_Valid, Addr_Err, Par_Err);
`else
  modport master (output WrEn, RdEn, Address, WrData,
                  input  RdData, RdData_Valid, Addr_Err);
  modport slave  (input  WrEn, RdEn, Address, WrData,
                  output RdData, RdData_Valid, Addr_Err);
`endif
endinterface

// File: rtl/reg_file_cfg.sv
// Register file with one-cycle registered read, write-over-read priority and
// out-of-range detection; entries 0..3 exported. Option: REG_FILE_PARITY_EN.
module reg_file_cfg
  import sys_cfg_pkg::*;
#(
  parameter int               WIDTH    = 8,
  parameter int               DEPTH    = 16,
  parameter int               ADDR     = 4,
  parameter logic [WIDTH-1:0] REG2_RST = WIDTH'(UART_CFG_RST),
  parameter logic [WIDTH-1:0] REG3_RST = WIDTH'(DIV_RATIO_RST)
) (
  input  logic             CLK,
  input  logic             RST,
  reg_file_cfg_if.slave    bus,
  output logic [WIDTH-1:0] REG0,
  output logic [WIDTH-1:0] REG1,
  output logic [WIDTH-1:0] REG2,
  output logic [WIDTH-1:0] REG3
);

  logic [WIDTH-1:0] mem [DEPTH];
`ifdef REG_FILE_PARITY_EN
  logic             par [DEPTH];
`endif

  logic inRange;
  logic wrFire;
  logic rdFire;

  function automatic logic [WIDTH-1:0] rstValue(int idx);
    if (idx == REG_UART_CFG)  return REG2_RST;
    if (idx == REG_DIV_RATIO) return REG3_RST;
    return '0;
  endfunction

  assign inRange = 32'(bus.Address) < DEPTH;
  assign wrFire  = bus.WrEn && inRange;
  // NOTE: a read colliding with a write is dropped outright, not bypassed.
  assign rdFire  = bus.RdEn && !bus.WrEn;

  // NOTE: storage is reset element by element because entries 2 and 3 carry
  // non-zero power-on defaults that downstream blocks rely on.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= rstValue(i);
`ifdef REG_FILE_PARITY_EN
        par[i] <= ^rstValue(i);
`endif
      end
      bus.RdData       <= '0;
      bus.RdData_Valid <= 1'b0;
      bus.Addr_Err     <= 1'b0;
`ifdef REG_FILE_PARITY_EN
      bus.Par_Err      <= 1'b0;
`endif
    end else begin
      bus.RdData_Valid <= rdFire;
      bus.Addr_Err     <= (bus.WrEn || bus.RdEn) && !inRange;
      if (wrFire) begin
        mem[bus.Address] <= bus.WrData;
`ifdef REG_FILE_PARITY_EN
        par[bus.Address] <= ^bus.WrData;
`endif
      end
      // Out-of-range reads still complete, returning zero, so the master never stalls.
      if (rdFire) bus.RdData <= inRange ? mem[bus.Address] : '0;
`ifdef REG_FILE_PARITY_EN
      bus.Par_Err <= rdFire && inRange && ((^mem[bus.Address]) != par[bus.Address]);
`endif
    end
  end

  assign REG0 = mem[REG_ALU_A];
  assign REG1 = mem[REG_ALU_B];
  assign REG2 = mem[REG_UART_CFG];
  assign REG3 = mem[REG_DIV_RATIO];

endmodule

// File: tb/tb_reg_file_cfg.sv
// Directed self-checking bench for reg_file_cfg (DEPTH=12 so that addresses
// 12..15 exercise out-of-range handling); parity checks under REG_FILE_PARITY_EN.
module tb_reg_file_cfg;

  localparam int WIDTH = 8;
  localparam int DEPTH = 12;
  localparam int ADDR  = 4;

  logic             CLK_tb;
  logic             RST;
  logic [WIDTH-1:0] REG0, REG1, REG2, REG3;

  int passCnt  = 0;
  int totalCnt = 0;

  reg_file_cfg_if #(.WIDTH(WIDTH), .ADDR(ADDR)) bus ();

  reg_file_cfg #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR)) dut (
    .CLK  (CLK_tb),
    .RST  (RST),
    .bus  (bus),
    .REG0 (REG0),
    .REG1 (REG1),
    .REG2 (REG2),
    .REG3 (REG3)
  );

  initial CLK_tb = 1'b0;
  always #5 CLK_tb = ~CLK_tb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalCnt++;
    if (got === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one rising edge and settle just past it.
  task automatic tick();
    @(posedge CLK_tb);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [ADDR-1:0] a,
                       input logic [WIDTH-1:0] d);
    bus.WrEn    = wr;
    bus.RdEn    = rd;
    bus.Address = a;
    bus.WrData  = d;
  endtask

  task automatic checkDefaults(input string tag);
    check({tag, "_reg0"}, 32'(REG0), 32'h00);
    check({tag, "_reg1"}, 32'(REG1), 32'h00);
    check({tag, "_reg2"}, 32'(REG2), 32'h81);
    check({tag, "_reg3"}, 32'(REG3), 32'd32);
    check({tag, "_rdata"}, 32'(bus.RdData), 32'h00);
    check({tag, "_valid"}, 32'(bus.RdData_Valid), 32'h0);
    check({tag, "_aerr"}, 32'(bus.Addr_Err), 32'h0);
  endtask

  initial begin
    RST = 1'b0;
    drive(1'b0, 1'b0, '0, '0);
    // Reset asserted between edges; outputs must settle without a clock edge.
    #2 RST = 1'b1;
    #1 checkDefaults("rst_async");
    tick();
    RST = 1'b0;

    // Write sweep over the whole address space; 12..15 lie outside DEPTH.
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, ADDR'(i), WIDTH'(8'h10 + i));
      tick();
      check($sformatf("wr_aerr_%0d", i), 32'(bus.Addr_Err), (i >= DEPTH) ? 32'h1 : 32'h0);
      check($sformatf("wr_valid_%0d", i), 32'(bus.RdData_Valid), 32'h0);
    end
    check("sweep_reg0", 32'(REG0), 32'h10);
    check("sweep_reg1", 32'(REG1), 32'h11);
    check("sweep_reg2", 32'(REG2), 32'h12);
    check("sweep_reg3", 32'(REG3), 32'h13);

    // Back-to-back reads with RdEn held: one result per edge.
    for (int i = 0; i < 16; i++) begin
      drive(1'b0, 1'b1, ADDR'(i), '0);
      tick();
      check($sformatf("rd_data_%0d", i), 32'(bus.RdData), (i >= DEPTH) ? 32'h0 : 32'(8'h10 + i));
      check($sformatf("rd_valid_%0d", i), 32'(bus.RdData_Valid), 32'h1);
      check($sformatf("rd_aerr_%0d", i), 32'(bus.Addr_Err), (i >= DEPTH) ? 32'h1 : 32'h0);
    end

    // Load a known non-zero RdData, then an idle cycle must hold it.
    drive(1'b0, 1'b1, 4'd3, '0);
    tick();
    check("rd3_data", 32'(bus.RdData), 32'h13);
    drive(1'b0, 1'b0, 4'd3, '0);
    tick();
    check("idle_valid", 32'(bus.RdData_Valid), 32'h0);
    check("idle_hold", 32'(bus.RdData), 32'h13);

    // Collision: write wins, read dropped.
    drive(1'b1, 1'b1, 4'd5, 8'hA5);
    tick();
    check("coll_valid", 32'(bus.RdData_Valid), 32'h0);
    check("coll_hold", 32'(bus.RdData), 32'h13);
    check("coll_aerr", 32'(bus.Addr_Err), 32'h0);
    drive(1'b0, 1'b1, 4'd5, '0);
    tick();
    check("coll_rd5", 32'(bus.RdData), 32'hA5);
    check("coll_rd5_valid", 32'(bus.RdData_Valid), 32'h1);

    // Read immediately after a write sees the new value.
    drive(1'b1, 1'b0, 4'd1, 8'h5C);
    tick();
    check("raw_reg1", 32'(REG1), 32'h5C);
    drive(1'b0, 1'b1, 4'd1, '0);
    tick();
    check("raw_rd1", 32'(bus.RdData), 32'h5C);

    // Out-of-range read and write.
    drive(1'b0, 1'b1, 4'd13, '0);
    tick();
    check("oor_rd_data", 32'(bus.RdData), 32'h0);
    check("oor_rd_valid", 32'(bus.RdData_Valid), 32'h1);
    check("oor_rd_aerr", 32'(bus.Addr_Err), 32'h1);
    drive(1'b1, 1'b0, 4'd14, 8'hFF);
    tick();
    check("oor_wr_aerr", 32'(bus.Addr_Err), 32'h1);
    check("oor_wr_valid", 32'(bus.RdData_Valid), 32'h0);
    drive(1'b0, 1'b0, 4'd0, '0);
    tick();
    check("oor_aerr_clear", 32'(bus.Addr_Err), 32'h0);
    check("oor_reg0", 32'(REG0), 32'h10);
    check("oor_reg3", 32'(REG3), 32'h13);
    drive(1'b0, 1'b1, 4'd11, '0);
    tick();
    check("oor_rd11", 32'(bus.RdData), 32'h1B);

`ifdef REG_FILE_PARITY_EN
    drive(1'b1, 1'b0, 4'd7, 8'h37);
    tick();
    dut.mem[7][0] = ~dut.mem[7][0];
    drive(1'b0, 1'b1, 4'd7, '0);
    tick();
    check("par_bad_valid", 32'(bus.RdData_Valid), 32'h1);
    check("par_bad_err", 32'(bus.Par_Err), 32'h1);
    drive(1'b0, 1'b1, 4'd6, '0);
    tick();
    check("par_ok_data", 32'(bus.RdData), 32'h16);
    check("par_ok_err", 32'(bus.Par_Err), 32'h0);
`endif

    // Reset in the middle of an issued read discards it.
    drive(1'b0, 1'b1, 4'd2, '0);
    #3 RST = 1'b1;
    #1 checkDefaults("rst_midread");
    tick();
    check("rst_hold_valid", 32'(bus.RdData_Valid), 32'h0);
    check("rst_hold_data", 32'(bus.RdData), 32'h0);
    drive(1'b0, 1'b0, '0, '0);
    RST = 1'b0;
    drive(1'b0, 1'b1, 4'd2, '0);
    tick();
    check("post_rst_rd2", 32'(bus.RdData), 32'h81);
    check("post_rst_valid", 32'(bus.RdData_Valid), 32'h1);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule

// File: doc/reg_file_cfg.md
Name: reg_file_cfg

Overview:
Parametrised successor to the single-port register file. It provides a synchronous write/read array with a registered read-data valid strobe, write-over-read priority, and out-of-range address detection. The lowest four entries are exported continuously as system configuration and ALU operand registers, each with a non-zero reset default where needed. It sits between the system controller (sole master) and the ALU, UART and clock-divider blocks.

Parameters:
WIDTH, 8, data width of each entry (min 8)
DEPTH, 16, number of entries (min 4)
ADDR, 4, address width; DEPTH <= 2**ADDR
REG2_RST, 8'b1000_0001, reset value of entry 2 (UART config: parity enable=1, parity type=0, prescale=32 in bits[7:2])
REG3_RST, 8'd32, reset value of entry 3 (clock divider ratio)

Ports:
CLK  input  1  system clock, all state on rising edge
RST  input  1  asynchronous, active-high reset
WrEn  input  1  write request
RdEn  input  1  read request
Address  input  ADDR  entry address for read or write
WrData  input  WIDTH  write data
RdData  output  WIDTH  registered read data
RdData_Valid  output  1  one-cycle strobe, RdData valid
Addr_Err  output  1  one-cycle strobe, access to Address >= DEPTH
REG0  output  WIDTH  entry 0 (ALU operand A), combinational from storage
REG1  output  WIDTH  entry 1 (ALU operand B)
REG2  output  WIDTH  entry 2 (UART config)
REG3  output  WIDTH  entry 3 (divider ratio)

Behaviour:
- Reset (RST=1, asynchronous, any time): all entries 0 except entry 2=REG2_RST and entry 3=REG3_RST; RdData=0, RdData_Valid=0, Addr_Err=0. Any in-flight read is discarded.
- Write: on the edge with WrEn=1 and RdEn=0, and Address < DEPTH, the entry is updated. The new value appears on REGn after that edge.
- Read: on the edge with RdEn=1 and WrEn=0, and Address < DEPTH, RdData is loaded with the entry and RdData_Valid=1 for exactly one cycle (latency 1).
- Idle cycle: RdData_Valid=0 and RdData holds its last value.
- Simultaneous WrEn=1 and RdEn=1: the write is performed and the read is dropped; RdData_Valid=0 and RdData holds.
- Out of range (Address >= DEPTH, either request): storage is unchanged and Addr_Err=1 for one cycle.
  - For a read, RdData=0 and RdData_Valid=1, so the master never stalls.
- Back-to-back reads: one result per cycle. RdData_Valid stays high continuously while RdEn is held.
- Read of an entry written on the previous edge returns the new value. There is no same-edge bypass, because write-over-read priority applies.
- No FSM beyond the one-stage read pipeline. Exported REGn are fixed at entries 0..3 independent of DEPTH.

Optional Feature:
REG_FILE_PARITY_EN:
- Defined: each entry stores an extra even-parity bit, computed at write and set to the matching parity of the reset value at reset.
- On a valid in-range read, the parity is recomputed. A mismatch asserts the extra output Par_Err (1 bit, one-cycle strobe aligned with RdData_Valid).
- Undefined: no parity storage and no Par_Err port. Behaviour is otherwise identical.

Decomposition:
- Shared package sys_cfg_pkg holds:
  - the entry indices (REG_ALU_A=0, REG_ALU_B=1, REG_UART_CFG=2, REG_DIV_RATIO=3);
  - the UART config field positions (PAR_EN bit0, PAR_TYP bit1, PRESCALE bits[7:2]);
  - the reset-default constants.
- Sub-module: none required. If REG_FILE_PARITY_EN is used, a small combinational parity_gen (even parity over WIDTH) is natural and shared with the UART.

Test Plan:
1. Reset check: assert RST=1 mid-cycle, then release -> all REGn/RdData read 0 except REG2=8'h81 and REG3=8'd32; RdData_Valid=0, with no clock edge required for the reset to take effect.
2. Write sweep then read back: write 8'h10+i to addresses 0..15, then read 0..15 with RdEn held -> RdData=8'h10+i one cycle after each address, RdData_Valid high 16 consecutive cycles; REG0=8'h10, REG3=8'h13.
3. Collision: WrEn=RdEn=1, Address=5, WrData=8'hA5 -> RdData_Valid=0 and RdData unchanged; the next read of address 5 gives 8'hA5.
4. Out of range with DEPTH=12: read address 13 -> RdData=0, RdData_Valid=1, Addr_Err=1; write 8'hFF to address 14 -> Addr_Err=1 and the entries are unchanged.
5. Reset mid-read: issue RdEn at address 2, then assert RST before the next edge -> RdData_Valid stays 0 and RdData=0.
6. With REG_FILE_PARITY_EN: force-corrupt one storage bit of entry 7 via hierarchical deposit, then read it -> Par_Err=1 with RdData_Valid; an uncorrupted read -> Par_Err=0.
